// File: rtl/ram_pkg.sv
// Shared definitions for the memory family: FSM state encoding and depth helper.
package ram_pkg;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  function automatic int unsigned depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/ram_sync_init_if.sv
// Access bus of ram_sync_init: enable, strobes, address/data and status.
interface ram_sync_init_if #(
  parameter int DW = 16,
  parameter int AW = 9
);
  logic          e;
  logic [DW-1:0] din;
  logic [AW-1:0] adr;
  logic          w;
  logic          r;
  logic          clr;
  logic [DW-1:0] dout;
  logic          rvalid;
  logic          busy;

  modport master (
    output e, din, adr, w, r, clr,
    input  dout, rvalid, busy
  );

  modport slave (
    input  e, din, adr, w, r, clr,
    output dout, rvalid, busy
  );
endinterface

// File: rtl/ram_rd_pipe.sv
// Read-data delay line of STAGES registers carrying {valid, data}; data only
// advances with a valid beat so the last stage holds the most recent read.
module ram_rd_pipe #(
  parameter int DW     = 16,
  parameter int STAGES = 1
) (
  input  logic          clk,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic [STAGES-1:0] valid_reg;
  logic [DW-1:0]     data_reg [STAGES];

  always_ff @(posedge clk) begin
    if (flush) begin
      valid_reg <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_reg[i] <= '0;
      end
    end else begin
      valid_reg[0] <= in_valid;
      if (in_valid) begin
        data_reg[0] <= in_data;
      end
      for (int i = 1; i < STAGES; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        if (valid_reg[i-1]) begin
          data_reg[i] <= data_reg[i-1];
        end
      end
    end
  end

  assign out_valid = valid_reg[STAGES-1];
  assign out_data  = data_reg[STAGES-1];

endmodule

// File: rtl/ram_sync_init.sv
// Single-port synchronous RAM with configurable read latency and a fill engine
// that writes INIT_VAL to every word after reset or on a clr request.
module ram_sync_init
  import ram_pkg::*;
#(
  parameter int            DW       = 16,
  parameter int            AW       = 9,
  parameter logic [DW-1:0] INIT_VAL = '0,
  parameter int            RD_LAT   = 1
) (
  input logic           clk,
  input logic           rst,
  ram_sync_init_if.slave bus
);

  localparam int unsigned DEPTH = depth(AW);

  generate
    if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_rd_lat
      $error("ram_sync_init: RD_LAT must be 1 or 2");
    end
  endgenerate

  logic [DW-1:0] mem [DEPTH];
  logic [0:0]    state_reg;
  logic [0:0]    state_next;
  logic [AW-1:0] ptr_reg;
  logic [AW-1:0] ptr_next;
  logic          busy;
  logic          accept;

  assign busy   = (state_reg == ST_CLEAR);
  assign accept = bus.e && !busy;

  // The fill reaches READY on the same edge that writes the last word.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    if (state_reg == ST_CLEAR) begin
      if (bus.clr) begin
        ptr_next = '0;
      end else if (ptr_reg == '1) begin
        state_next = ST_READY;
        ptr_next   = '0;
      end else begin
        ptr_next = ptr_reg + 1'b1;
      end
    end else if (bus.clr) begin
      state_next = ST_CLEAR;
      ptr_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_CLEAR;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Storage carries no reset; only the fill engine or accepted writes change it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        mem[ptr_reg] <= INIT_VAL;
      end else if (accept && bus.w) begin
        mem[bus.adr] <= bus.din;
      end
    end
  end

  ram_rd_pipe #(
    .DW     (DW),
    .STAGES (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .flush     (rst),
    .in_valid  (accept && bus.r),
    .in_data   (mem[bus.adr]),
    .out_valid (bus.rvalid),
    .out_data  (bus.dout)
  );

  assign bus.busy = busy;

endmodule

// File: doc/ram_sync_init.md
Name: ram_sync_init

Overview:
Parametrised single-port synchronous RAM, successor to the fixed 512x16 RAM. It adds a configurable read latency with a read-valid strobe, and a hardware initialisation engine. The engine fills every word with INIT_VAL after reset or on request. It is used as the generic scratch/buffer memory for the lab datapaths and stands in for RAM512 where width or depth differ.

Parameters:
DW, 16, data width in bits (>=1)
AW, 9, address width; depth = 2**AW words
INIT_VAL, 0, value written to every word by the init engine (DW bits)
RD_LAT, 1, read latency in cycles, legal values 1 or 2

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
e  input  1  chip enable; when 0, r and w are ignored
din  input  DW  write data
adr  input  AW  word address for read and write
w  input  1  write strobe
r  input  1  read strobe
clr  input  1  request re-initialisation, sampled each cycle
dout  output  DW  read data, registered
rvalid  output  1  one-cycle pulse: dout holds data of a read issued RD_LAT cycles earlier
busy  output  1  init engine running; all accesses ignored

Behaviour:
- Reset (rst=1 at an edge): dout=0, rvalid=0, read pipeline flushed, FSM enters CLEAR with the fill pointer at 0, busy=1 from the next cycle.
- Memory contents are not reset directly; only the init engine changes them.
- FSM states: CLEAR, READY.
- CLEAR: each cycle writes INIT_VAL to mem[ptr] and increments ptr. The write to ptr=2**AW-1 moves the FSM to READY on that edge.
- CLEAR takes exactly 2**AW cycles; busy=1 throughout and busy=0 in the first READY cycle.
- READY -> CLEAR when clr=1 at an edge (ptr reset to 0).
- clr during CLEAR restarts the fill at ptr=0.
- rst during CLEAR restarts the fill at ptr=0 and flushes the pipeline.
- Accesses are accepted only when e=1 and busy=0; otherwise r and w are ignored (no write, no rvalid).
- Write: w=1 writes din to mem[adr] at the edge.
- Read: r=1 samples adr. With RD_LAT=1, dout and rvalid update at the next edge. With RD_LAT=2, one extra register stage follows.
- r=1 and w=1 in the same cycle: both are performed, read-first. The read returns the old contents of mem[adr] and the new value is stored.
- dout holds its last value when no read completes. rvalid is 0 in every cycle without a completing read.
- Back-to-back reads: one per cycle, fully pipelined, no bubbles.
- A read accepted in the cycle before clr was sampled still completes normally.
- clr in the same cycle as r/w while READY: the access is accepted and performed; the init starts at the same edge.
- Address wrap is not applicable: adr always indexes within 2**AW.
- RD_LAT outside {1,2}: elaboration error via generate-time check.

Decomposition:
- Shared package ram_pkg: FSM state encoding (ST_CLEAR, ST_READY) and a depth function (2**AW), both reused by future FIFO/ROM blocks.
- One sub-module, ram_rd_pipe: a DW+1-bit delay line of RD_LAT stages carrying {valid, data}, with synchronous flush.
- Storage array, FSM and pointer live in the top.

Test Plan:
- Reset-init, DW=16, AW=9, INIT_VAL=16'hA5A5: pulse rst -> busy high for exactly 512 cycles, then low. Reads of addresses 0, 255 and 511 return A5A5, each with an rvalid pulse 1 cycle after r.
- Write/read sweep as RAM512, RD_LAT=1: write din=i to adr=i for i=0..63, then read 0..63 back-to-back -> dout=i with rvalid every cycle, 1-cycle latency.
- Read-first collision: mem[5]=16'h0007; apply r=1, w=1, adr=5, din=16'h0009 -> dout=0007. A subsequent read of address 5 returns 0009.
- RD_LAT=2, back-to-back reads of addresses 1, 2, 3 holding 10, 20, 30 -> rvalid high on cycles +2, +3, +4 with dout 10, 20, 30. No write reaches memory when e=0.
- Access while busy and mid-init restart: assert clr; during busy, attempt w to adr 3 -> ignored, mem[3]=INIT_VAL, no rvalid. Assert rst at fill ptr=100 -> busy stays high for a fresh 512 cycles.
- Small config DW=8, AW=3, INIT_VAL=8'hFF: busy lasts 8 cycles. Write 8'h3C to adr 7 then read -> 3C. clr then read of adr 7 -> FF.
